uart_fifo_sched: RTL and testbench
==================================

// Module: uart_fifo_sched
// PURPOSE
//   Bus master that sequences the UART peripheral's 32-bit slave port for the CPU.
//   Buffers outbound bytes in a TX FIFO and inbound bytes in an RX FIFO.
//   Issues single-cycle strobes to write TX data, read RX data and program the divisor,
//   serialised through one scheduler FSM; paced by the UART's rx_irq/tx_irq pulses.
// PARAMETERS
//   TX_DEPTH  16  TX FIFO entries, power of 2, >=2
//   RX_DEPTH  16  RX FIFO entries, power of 2, >=2
//   DIV_INIT  54  divisor written to UART after reset (100 MHz / 115200 / 16)
// PORTS
//   sys_clk       in   1   clock
//   sys_rst_n     in   1   asynchronous, active-low reset
//   cpu_tx_data   in   8   byte to transmit
//   cpu_tx_valid  in   1   push request
//   cpu_tx_ready  out  1   TX FIFO not full
//   cpu_rx_data   out  8   head of RX FIFO (first-word fall-through)
//   cpu_rx_valid  out  1   RX FIFO not empty
//   cpu_rx_ready  in   1   pop request
//   cfg_div       in   16  new baud divisor
//   cfg_div_wr    in   1   latch cfg_div, schedule divisor write
//   ovf_clr       in   1   clear rx_overflow
//   tx_level      out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
//   rx_level      out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
//   rx_overflow   out  1   sticky: received byte lost
//   u_dat_o       out  32  write data to UART
//   u_adr_o       out  32  UART register address (0 data, 1 divisor)
//   u_we_o        out  1   write enable
//   u_stb_o       out  1   strobe (UART acks combinationally in same cycle)
//   u_dat_i       in   32  UART read data, valid the cycle after a read strobe
//   u_rx_irq      in   1   one-cycle pulse: UART received a byte
//   u_tx_irq      in   1   one-cycle pulse: UART finished sending a byte
// BEHAVIOUR
//   Reset: u_* = 0, cpu_tx_ready=1, cpu_rx_valid=0, levels=0, rx_overflow=0, state=IDLE,
//     tx_busy=0, rx_pend=0, div_pend=1, div_shadow=DIV_INIT. Clears FIFOs instantly.
//   FSM states IDLE, RX_RD, RX_CAP, DIV_WR, TX_WR; u_stb_o high only in RX_RD/DIV_WR/TX_WR.
//   IDLE priority: rx_pend -> RX_RD; else div_pend & !tx_busy -> DIV_WR;
//     else TX FIFO non-empty & !tx_busy -> TX_WR; else stay.
//   RX_RD (1 cyc): stb=1, we=0, adr=0; clears rx_pend; -> RX_CAP.
//   RX_CAP (1 cyc): push u_dat_i[7:0] into RX FIFO; -> IDLE.
//   DIV_WR (1 cyc): stb=1, we=1, adr=1, dat={16'd0,div_shadow}; clears div_pend; -> IDLE.
//   TX_WR (1 cyc): stb=1, we=1, adr=0, dat={24'd0,TX head}; pop TX FIFO; tx_busy<=1; -> IDLE.
//   u_dat_o/u_adr_o/u_we_o = 0 whenever u_stb_o = 0.
//   tx_busy cleared by u_tx_irq; next TX_WR no earlier than cycle after that pulse.
//   TX latency: u_stb_o for a byte asserts the cycle after IDLE first sees it at FIFO head.
//   u_rx_irq sets rx_pend; u_rx_irq while rx_pend=1 sets rx_overflow (byte overwritten).
//   RX push when full: accepted if cpu pops same cycle, else dropped and rx_overflow<=1.
//   TX push accepted iff cpu_tx_valid & cpu_tx_ready; push+pop same cycle keeps level.
//   cfg_div_wr: div_shadow<=cfg_div, div_pend<=1; repeat while pending overwrites shadow.
//   Divisor never changes mid-byte: DIV_WR waits for tx_busy=0.
//   ovf_clr clears rx_overflow; a same-cycle overflow event wins (stays 1).
//   Pointers wrap modulo depth; level = wr_cnt - rd_cnt with one extra MSB.
//   Reset mid-operation aborts any strobe; the UART must be reset in the same event.
// TESTING
//   Reset release -> one DIV_WR strobe, adr=1, dat=54, before any TX strobe.
//   Push 0x41,0x42,0x43 -> three TX_WR strobes with those bytes, each only after a u_tx_irq.
//   u_rx_irq pulse, u_dat_i=0x5A next cycle -> cpu_rx_valid=1, cpu_rx_data=0x5A, rx_level=1.
//   Fill RX to 16, one more rx byte with no pop -> byte dropped, rx_overflow=1; ovf_clr -> 0.
//   cfg_div_wr(27) while tx_busy -> DIV_WR(dat=27) only after u_tx_irq, before next TX_WR.
//   u_rx_irq and TX FIFO non-empty in same IDLE cycle -> RX_RD served first, then TX_WR.

Source files
------------

// File: rtl/uart_fifo_sched.sv
// uart_fifo_sched: bus master that drives the UART slave port on behalf of the CPU.
// Outbound bytes queue in a TX FIFO and inbound bytes in an RX FIFO. One scheduler
// FSM serialises the three kinds of UART access (RX data read, divisor write,
// TX data write). The UART's rx_irq/tx_irq pulses pace the scheduler.
module uart_fifo_sched #(
    parameter int          TX_DEPTH = 16,
    parameter int          RX_DEPTH = 16,
    parameter logic [15:0] DIV_INIT = 16'd54
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic [7:0]                  cpu_tx_data,
    input  logic                        cpu_tx_valid,
    output logic                        cpu_tx_ready,
    output logic [7:0]                  cpu_rx_data,
    output logic                        cpu_rx_valid,
    input  logic                        cpu_rx_ready,
    input  logic [15:0]                 cfg_div,
    input  logic                        cfg_div_wr,
    input  logic                        ovf_clr,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic                        rx_overflow,
    output logic [31:0]                 u_dat_o,
    output logic [31:0]                 u_adr_o,
    output logic                        u_we_o,
    output logic                        u_stb_o,
    input  logic [31:0]                 u_dat_i,
    input  logic                        u_rx_irq,
    input  logic                        u_tx_irq
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_LVL = (RX_AW+1)'(RX_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RX_RD,
        RX_CAP,
        DIV_WR,
        TX_WR
    } state_t;

    state_t           r_state;
    logic             r_rx_pend;
    logic             r_div_pend;
    logic             r_tx_busy;
    logic [15:0]      r_div_shadow;

    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [TX_AW:0]   r_tx_wr_cnt;
    logic [TX_AW:0]   r_tx_rd_cnt;
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW:0]   r_rx_wr_cnt;
    logic [RX_AW:0]   r_rx_rd_cnt;

    logic [TX_AW:0]   w_tx_level;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic [7:0]       w_tx_head;

    logic [RX_AW:0]   w_rx_level;
    logic             w_rx_full;
    logic             w_rx_pop;
    logic             w_rx_cap;
    logic             w_rx_push;
    logic             w_rx_drop;
    logic             w_ovf_set;
    logic             w_unused_dat;

    // Only the low byte of a UART read carries data.
    assign w_unused_dat = ^u_dat_i[31:8];

    assign w_tx_level   = r_tx_wr_cnt - r_tx_rd_cnt;
    assign w_tx_full    = (w_tx_level == TX_FULL_LVL);
    assign w_tx_empty   = (r_tx_wr_cnt == r_tx_rd_cnt);
    assign w_tx_push    = cpu_tx_valid & ~w_tx_full;
    assign w_tx_pop     = (r_state == TX_WR);
    assign w_tx_head    = r_tx_mem[r_tx_rd_cnt[TX_AW-1:0]];
    assign cpu_tx_ready = ~w_tx_full;
    assign tx_level     = w_tx_level;

    // A capture into a full RX FIFO survives only if the CPU frees a slot that same cycle.
    assign w_rx_level   = r_rx_wr_cnt - r_rx_rd_cnt;
    assign w_rx_full    = (w_rx_level == RX_FULL_LVL);
    assign cpu_rx_valid = (r_rx_wr_cnt != r_rx_rd_cnt);
    assign w_rx_pop     = cpu_rx_ready & cpu_rx_valid;
    assign w_rx_cap     = (r_state == RX_CAP);
    assign w_rx_push    = w_rx_cap & (~w_rx_full | w_rx_pop);
    assign w_rx_drop    = w_rx_cap & w_rx_full & ~w_rx_pop;
    assign cpu_rx_data  = r_rx_mem[r_rx_rd_cnt[RX_AW-1:0]];
    assign rx_level     = w_rx_level;

    // A byte is lost either when the UART overwrites an unread byte or when RX is full.
    assign w_ovf_set    = (u_rx_irq & r_rx_pend) | w_rx_drop;

    // TX FIFO storage; reset only needs to clear the counters.
    always_ff @(posedge sys_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr_cnt[TX_AW-1:0]] <= cpu_tx_data;
    end

    // TX FIFO write/read counters, one extra MSB to tell full from empty.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tx_wr_cnt <= '0;
            r_tx_rd_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr_cnt <= r_tx_wr_cnt + 1'b1;
            if (w_tx_pop)  r_tx_rd_cnt <= r_tx_rd_cnt + 1'b1;
        end
    end

    // RX FIFO storage, written with the byte captured from the UART.
    always_ff @(posedge sys_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wr_cnt[RX_AW-1:0]] <= u_dat_i[7:0];
    end

    // RX FIFO write/read counters.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_wr_cnt <= '0;
            r_rx_rd_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wr_cnt <= r_rx_wr_cnt + 1'b1;
            if (w_rx_pop)  r_rx_rd_cnt <= r_rx_rd_cnt + 1'b1;
        end
    end

    // Sticky overflow flag; a new loss in the clearing cycle keeps it set.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)     rx_overflow <= 1'b0;
        else if (w_ovf_set) rx_overflow <= 1'b1;
        else if (ovf_clr)   rx_overflow <= 1'b0;
    end

    // Scheduler: picks one UART access per visit to IDLE, bus outputs registered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= IDLE;
            r_rx_pend    <= 1'b0;
            r_div_pend   <= 1'b1;
            r_tx_busy    <= 1'b0;
            r_div_shadow <= DIV_INIT;
            u_stb_o      <= 1'b0;
            u_we_o       <= 1'b0;
            u_adr_o      <= '0;
            u_dat_o      <= '0;
        end else begin
            u_stb_o <= 1'b0;
            u_we_o  <= 1'b0;
            u_adr_o <= '0;
            u_dat_o <= '0;

            if (u_rx_irq)
                r_rx_pend <= 1'b1;
            else if (r_state == RX_RD)
                r_rx_pend <= 1'b0;

            if (cfg_div_wr) begin
                r_div_shadow <= cfg_div;
                r_div_pend   <= 1'b1;
            end else if (r_state == DIV_WR) begin
                r_div_pend   <= 1'b0;
            end

            if (r_state == TX_WR)
                r_tx_busy <= 1'b1;
            else if (u_tx_irq)
                r_tx_busy <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_rx_pend) begin
                        r_state <= RX_RD;
                        u_stb_o <= 1'b1;
                    end else if (r_div_pend && !r_tx_busy) begin
                        r_state <= DIV_WR;
                        u_stb_o <= 1'b1;
                        u_we_o  <= 1'b1;
                        u_adr_o <= 32'd1;
                        u_dat_o <= {16'd0, (cfg_div_wr ? cfg_div : r_div_shadow)};
                    end else if (!w_tx_empty && !r_tx_busy) begin
                        r_state <= TX_WR;
                        u_stb_o <= 1'b1;
                        u_we_o  <= 1'b1;
                        u_dat_o <= {24'd0, w_tx_head};
                    end
                end
                RX_RD:   r_state <= RX_CAP;
                RX_CAP:  r_state <= IDLE;
                DIV_WR:  r_state <= IDLE;
                TX_WR:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_sched.sv
// tb_uart_fifo_sched: directed bench for uart_fifo_sched. The bench plays the UART:
// it records every strobe, answers read strobes with a byte one cycle later and
// issues rx/tx interrupt pulses by hand.
module tb_uart_fifo_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  cpu_tx_data = '0;
    logic        cpu_tx_valid = 1'b0;
    logic        cpu_tx_ready;
    logic [7:0]  cpu_rx_data;
    logic        cpu_rx_valid;
    logic        cpu_rx_ready = 1'b0;
    logic [15:0] cfg_div = '0;
    logic        cfg_div_wr = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [4:0]  tx_level;
    logic [4:0]  rx_level;
    logic        rx_overflow;
    logic [31:0] u_dat_o;
    logic [31:0] u_adr_o;
    logic        u_we_o;
    logic        u_stb_o;
    logic [31:0] u_dat_i = '0;
    logic        u_rx_irq = 1'b0;
    logic        u_tx_irq = 1'b0;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } strobeT;

    strobeT      strobeQ[$];
    int          checkCount = 0;
    int          failCount  = 0;
    int          idleNoise  = 0;
    logic [7:0]  rxByte     = '0;
    logic        readSeen   = 1'b0;

    uart_fifo_sched #(
        .TX_DEPTH(16),
        .RX_DEPTH(16),
        .DIV_INIT(16'd54)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cpu_tx_data (cpu_tx_data),
        .cpu_tx_valid(cpu_tx_valid),
        .cpu_tx_ready(cpu_tx_ready),
        .cpu_rx_data (cpu_rx_data),
        .cpu_rx_valid(cpu_rx_valid),
        .cpu_rx_ready(cpu_rx_ready),
        .cfg_div     (cfg_div),
        .cfg_div_wr  (cfg_div_wr),
        .ovf_clr     (ovf_clr),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .rx_overflow (rx_overflow),
        .u_dat_o     (u_dat_o),
        .u_adr_o     (u_adr_o),
        .u_we_o      (u_we_o),
        .u_stb_o     (u_stb_o),
        .u_dat_i     (u_dat_i),
        .u_rx_irq    (u_rx_irq),
        .u_tx_irq    (u_tx_irq)
    );

    always #5 sys_clk = ~sys_clk;

    // UART stand-in: log strobes, flag bus noise, return rxByte the cycle after a read.
    always @(negedge sys_clk) begin
        if (u_stb_o)
            strobeQ.push_back({u_we_o, u_adr_o, u_dat_o});
        else if (u_we_o || (u_adr_o != 32'd0) || (u_dat_o != 32'd0))
            idleNoise++;
        u_dat_i  = readSeen ? {24'd0, rxByte} : 32'hCAFE_F0EE;
        readSeen = u_stb_o & ~u_we_o & sys_rst_n;
    end

    // Hard stop in case something never returns.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkStrobe(input string tag, input int idx, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat);
        if (idx < strobeQ.size()) begin
            checkOutput({tag, "_we"},  32'(strobeQ[idx].we), 32'(we));
            checkOutput({tag, "_adr"}, strobeQ[idx].adr, adr);
            checkOutput({tag, "_dat"}, strobeQ[idx].dat, dat);
        end else begin
            checkOutput({tag, "_present"}, 32'(strobeQ.size()), 32'(idx + 1));
        end
    endtask

    // Drive one cycle of inputs starting at a negedge, then return everything to idle.
    task automatic applyStimulus(input logic txValid, input logic [7:0] txData,
                                 input logic rxIrq, input logic txIrq,
                                 input logic divWr, input logic [15:0] div,
                                 input logic ovfClr, input logic rxReady);
        cpu_tx_valid = txValid;
        cpu_tx_data  = txData;
        u_rx_irq     = rxIrq;
        u_tx_irq     = txIrq;
        cfg_div_wr   = divWr;
        cfg_div      = div;
        ovf_clr      = ovfClr;
        cpu_rx_ready = rxReady;
        @(negedge sys_clk);
        cpu_tx_valid = 1'b0;
        u_rx_irq     = 1'b0;
        u_tx_irq     = 1'b0;
        cfg_div_wr   = 1'b0;
        ovf_clr      = 1'b0;
        cpu_rx_ready = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pushTx(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic txIrq();
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic rxIrq(input logic [7:0] b);
        rxByte = b;
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic popRx();
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    endtask

    initial begin
        bit found;

        // Reset values while reset is held.
        tick(3);
        checkOutput("rst_stb",      32'(u_stb_o),      32'd0);
        checkOutput("rst_tx_ready", 32'(cpu_tx_ready), 32'd1);
        checkOutput("rst_rx_valid", 32'(cpu_rx_valid), 32'd0);
        checkOutput("rst_tx_level", 32'(tx_level),     32'd0);
        checkOutput("rst_rx_level", 32'(rx_level),     32'd0);
        checkOutput("rst_overflow", 32'(rx_overflow),  32'd0);

        // Release: exactly one divisor write of 54.
        sys_rst_n = 1'b1;
        tick(6);
        checkOutput("init_strobes", 32'(strobeQ.size()), 32'd1);
        checkStrobe("init_div", 0, 1'b1, 32'd1, 32'd54);
        strobeQ.delete();

        // Three TX bytes, each released by a tx_irq.
        pushTx(8'h41);
        pushTx(8'h42);
        pushTx(8'h43);
        tick(4);
        checkStrobe("tx0", 0, 1'b1, 32'd0, 32'h41);
        checkOutput("tx_level_a", 32'(tx_level), 32'd2);
        tick(8);
        checkOutput("tx_wait_busy", 32'(strobeQ.size()), 32'd1);
        txIrq();
        tick(4);
        checkOutput("tx_cnt_b", 32'(strobeQ.size()), 32'd2);
        checkStrobe("tx1", 1, 1'b1, 32'd0, 32'h42);
        checkOutput("tx_level_b", 32'(tx_level), 32'd1);
        txIrq();
        tick(4);
        checkStrobe("tx2", 2, 1'b1, 32'd0, 32'h43);
        checkOutput("tx_level_c", 32'(tx_level), 32'd0);
        txIrq();
        tick(3);
        checkOutput("tx_cnt_end", 32'(strobeQ.size()), 32'd3);
        strobeQ.delete();

        // Single RX byte.
        rxIrq(8'h5A);
        tick(5);
        checkStrobe("rx_rd", 0, 1'b0, 32'd0, 32'd0);
        checkOutput("rx_valid", 32'(cpu_rx_valid), 32'd1);
        checkOutput("rx_data",  32'(cpu_rx_data),  32'h5A);
        checkOutput("rx_level1", 32'(rx_level),    32'd1);
        popRx();
        checkOutput("rx_level0", 32'(rx_level),    32'd0);
        checkOutput("rx_valid0", 32'(cpu_rx_valid), 32'd0);
        strobeQ.delete();

        // Fill RX to 16, then overflow.
        for (int i = 0; i < 16; i++) begin
            rxIrq(8'h10 + 8'(i));
            tick(4);
        end
        checkOutput("rx_full_level", 32'(rx_level),    32'd16);
        checkOutput("rx_full_ovf",   32'(rx_overflow), 32'd0);
        checkOutput("rx_full_head",  32'(cpu_rx_data), 32'h10);
        rxIrq(8'h99);
        tick(4);
        checkOutput("rx_drop_level", 32'(rx_level),    32'd16);
        checkOutput("rx_drop_ovf",   32'(rx_overflow), 32'd1);
        checkOutput("rx_drop_head",  32'(cpu_rx_data), 32'h10);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
        checkOutput("ovf_clr", 32'(rx_overflow), 32'd0);

        // Full RX with a CPU pop in the capture cycle: the new byte is kept.
        rxIrq(8'hA5);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge sys_clk);
            if (u_stb_o && !u_we_o) found = 1'b1;
        end
        checkOutput("rd_strobe_seen", 32'(found), 32'd1);
        @(negedge sys_clk);
        popRx();
        tick(2);
        checkOutput("rx_swap_level", 32'(rx_level),    32'd16);
        checkOutput("rx_swap_ovf",   32'(rx_overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("rx_drain%0d", i), 32'(cpu_rx_data),
                        (i < 15) ? 32'(8'h11 + 8'(i)) : 32'hA5);
            popRx();
        end
        checkOutput("rx_drained", 32'(rx_level), 32'd0);
        strobeQ.delete();

        // Divisor update while a byte is in flight waits for tx_irq, then precedes next TX.
        pushTx(8'h61);
        pushTx(8'h62);
        tick(4);
        checkStrobe("div_tx0", 0, 1'b1, 32'd0, 32'h61);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 16'd27, 1'b0, 1'b0);
        tick(6);
        checkOutput("div_held", 32'(strobeQ.size()), 32'd1);
        txIrq();
        tick(8);
        checkOutput("div_cnt", 32'(strobeQ.size()), 32'd3);
        checkStrobe("div_wr", 1, 1'b1, 32'd1, 32'd27);
        checkStrobe("div_tx1", 2, 1'b1, 32'd0, 32'h62);
        txIrq();
        tick(3);
        strobeQ.delete();

        // rx_irq and a TX byte arriving together: read served first.
        rxByte = 8'h3C;
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        tick(8);
        checkOutput("prio_cnt", 32'(strobeQ.size()), 32'd2);
        checkStrobe("prio_rd", 0, 1'b0, 32'd0, 32'd0);
        checkStrobe("prio_tx", 1, 1'b1, 32'd0, 32'h77);
        checkOutput("prio_rx_data", 32'(cpu_rx_data), 32'h3C);
        popRx();
        txIrq();
        tick(3);

        checkOutput("bus_quiet_when_idle", 32'(idleNoise), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
